// File: rtl/pe_array_sequencer_pkg.sv
// pe_array_pkg: PE control codes, ALU ops and sequencer states shared by the PE array slice
package pe_array_pkg;
  typedef enum logic [1:0] {
    CTRL_LOAD  = 2'b00,
    CTRL_EXEC  = 2'b01,
    CTRL_STORE = 2'b10,
    CTRL_HOLD  = 2'b11
  } ctrl_e;
  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_MUL = 3'b001
  } op_e;
  typedef enum logic [2:0] {IDLE, LOAD, MUL, ACC, STORE, REDUCE} state_e;
endpackage

// File: rtl/pe_array_sequencer_if.sv
// pe_array_sequencer_if: buffer handshake, PE array buses and pass control for the sequencer
interface pe_array_sequencer_if #(
  parameter int N_PE   = 4,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 16,
  parameter int TAP_W  = 4
) ();
  logic                            start;
  logic [TAP_W-1:0]                num_taps;
  logic                            in_valid;
  logic                            in_ready;
  logic [N_PE*DATA_W-1:0]          data_in;
  logic [N_PE*DATA_W-1:0]          filter_in;
  logic [N_PE*DATA_W-1:0]          pe_data;
  logic [N_PE*DATA_W-1:0]          pe_filter;
  logic [N_PE*2-1:0]               pe_control;
  logic [N_PE*3-1:0]               pe_control2;
  logic [N_PE*ACC_W-1:0]           pe_output;
  logic [ACC_W+$clog2(N_PE)-1:0]   result;
  logic                            result_valid;
  logic                            busy;
  logic                            done;
  modport master (
    input  start, num_taps, in_valid, data_in, filter_in, pe_output,
    output in_ready, pe_data, pe_filter, pe_control, pe_control2, result, result_valid, busy, done
  );
  modport slave (
    output start, num_taps, in_valid, data_in, filter_in, pe_output,
    input  in_ready, pe_data, pe_filter, pe_control, pe_control2, result, result_valid, busy, done
  );
endinterface

// File: rtl/pe_array_sequencer_reduce_tree.sv
// pe_reduce_tree: combinational sum of N_PE accumulator lanes, widened so it cannot overflow
module pe_reduce_tree #(
  parameter int N_PE  = 4,
  parameter int ACC_W = 16,
  parameter int OUT_W = ACC_W + $clog2(N_PE)
) (
  input  logic [N_PE*ACC_W-1:0] lanes,
  output logic [OUT_W-1:0]      sum
);
  always_comb begin
    sum = '0;
    for (int i = 0; i < N_PE; i++) sum = sum + OUT_W'(lanes[i*ACC_W +: ACC_W]);
  end
endmodule

// File: rtl/pe_array_sequencer.sv
// pe_array_sequencer: start/done engine running LOAD/MUL/ACC per tap, then STORE and a lane reduction
module pe_array_sequencer
  import pe_array_pkg::*;
#(
  parameter int N_PE   = 4,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 16,
  parameter int TAP_W  = 4
) (
  input logic            clk,
  input logic            rst,
  pe_array_sequencer_if.master bus
);
  localparam int RES_W = ACC_W + $clog2(N_PE);
  state_e           state, state_n;
  ctrl_e            ctrl;
  op_e              op;
  logic [TAP_W-1:0] taps, tap_cnt;
  logic [RES_W-1:0] sum;
  logic             last_tap;
  assign last_tap = tap_cnt == taps - 1'b1;
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    state_n = bus.start ? LOAD : IDLE;
      LOAD:    state_n = bus.in_valid ? MUL : LOAD;
      MUL:     state_n = ACC;
      ACC:     state_n = last_tap ? STORE : LOAD;
      STORE:   state_n = REDUCE;
      REDUCE:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_comb begin
    ctrl = state == LOAD ? CTRL_LOAD :
           (state == MUL || state == ACC) ? CTRL_EXEC :
           state == STORE ? CTRL_STORE : CTRL_HOLD;
    op              = state == MUL ? OP_MUL : OP_ADD;
    bus.pe_control  = {N_PE{ctrl}};
    bus.pe_control2 = {N_PE{op}};
    bus.in_ready    = state == LOAD;
    bus.busy        = state != IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      taps             <= '0;
      tap_cnt          <= '0;
      bus.pe_data      <= '0;
      bus.pe_filter    <= '0;
      bus.result       <= '0;
      bus.result_valid <= 1'b0;
    end else begin
      if (state == IDLE && bus.start) begin
        taps    <= bus.num_taps == '0 ? TAP_W'(1) : bus.num_taps;
        tap_cnt <= '0;
      end
      if (state == LOAD && bus.in_valid) begin
        bus.pe_data   <= bus.data_in;
        bus.pe_filter <= bus.filter_in;
      end
      if (state == ACC && !last_tap) tap_cnt <= tap_cnt + 1'b1;
      if (state == REDUCE) bus.result <= sum;
      bus.result_valid <= state == REDUCE;
    end
  end
  assign bus.done = bus.result_valid;
  pe_reduce_tree #(.N_PE(N_PE), .ACC_W(ACC_W)) u_reduce (
    .lanes(bus.pe_output),
    .sum  (sum)
  );
endmodule

// File: tb/tb_pe_array_sequencer.sv
// tb_pe_array_sequencer: directed scenarios against a behavioural 4-PE multiply-accumulate model
module tb_pe_array_sequencer;
  import pe_array_pkg::*;
  localparam logic [31:0] D1 = 32'h40302010;
  localparam logic [31:0] F1 = 32'h04030201;
  localparam logic [31:0] D2 = 32'h04030201;
  localparam logic [31:0] F2 = 32'h08070605;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic force_ff = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [15:0] prod [4];
  logic [15:0] acc  [4];
  logic [15:0] outr [4];
  always #5 clk = ~clk;
  pe_array_sequencer_if bus ();
  pe_array_sequencer dut (.clk(clk), .rst(rst), .bus(bus));
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (rst) begin
        prod[i] <= '0;
        acc[i]  <= '0;
        outr[i] <= '0;
      end else if (bus.pe_control[i*2 +: 2] == CTRL_EXEC && bus.pe_control2[i*3 +: 3] == OP_MUL) begin
        prod[i] <= 16'(bus.pe_data[i*8 +: 8]) * 16'(bus.pe_filter[i*8 +: 8]);
      end else if (bus.pe_control[i*2 +: 2] == CTRL_EXEC && bus.pe_control2[i*3 +: 3] == OP_ADD) begin
        acc[i] <= acc[i] + prod[i];
      end else if (bus.pe_control[i*2 +: 2] == CTRL_STORE) begin
        outr[i] <= acc[i];
        acc[i]  <= '0;
      end
    end
  end
  always_comb begin
    bus.pe_output = '0;
    for (int i = 0; i < 4; i++) bus.pe_output[i*16 +: 16] = force_ff ? 16'hFFFF : outr[i];
  end
  task automatic start_pass(input logic [3:0] nt);
    @(negedge clk);
    bus.num_taps = nt;
    bus.start    = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask
  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.pe_control !== 8'hFF) begin errors++; $display("FAIL reset_ctrl got %h exp ff", bus.pe_control); end
    checks++;
    if (bus.pe_control2 !== 12'h000) begin errors++; $display("FAIL reset_op got %h exp 000", bus.pe_control2); end
    checks++;
    if ({bus.busy, bus.in_ready, bus.result_valid, bus.done} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags got %b exp 0000", {bus.busy, bus.in_ready, bus.result_valid, bus.done});
    end
    checks++;
    if ({bus.pe_data, bus.pe_filter, bus.result} !== '0) begin
      errors++; $display("FAIL reset_data got %h %h %h exp 0", bus.pe_data, bus.pe_filter, bus.result);
    end
    rst = 1'b0;
  endtask
  task automatic test_single_tap;
    logic [1:0] ec [5];
    logic [2:0] eo [5];
    ec = '{CTRL_LOAD, CTRL_EXEC, CTRL_EXEC, CTRL_STORE, CTRL_HOLD};
    eo = '{OP_ADD, OP_MUL, OP_ADD, OP_ADD, OP_ADD};
    bus.data_in   = D1;
    bus.filter_in = F1;
    bus.in_valid  = 1'b1;
    start_pass(4'd1);
    for (int c = 1; c <= 5; c++) begin
      checks++;
      if (bus.pe_control !== {4{ec[c-1]}} || bus.pe_control2 !== {4{eo[c-1]}}) begin
        errors++; $display("FAIL single_seq c%0d got %h/%h exp %h/%h", c, bus.pe_control, bus.pe_control2, {4{ec[c-1]}}, {4{eo[c-1]}});
      end
      if (c == 2) bus.data_in = 32'hFFFFFFFF;
      if (c == 3) begin
        checks++;
        if (bus.pe_data !== D1 || bus.pe_filter !== F1) begin
          errors++; $display("FAIL single_nocap got %h/%h exp %h/%h", bus.pe_data, bus.pe_filter, D1, F1);
        end
        bus.data_in = D1;
      end
      checks++;
      if (bus.done !== 1'b0) begin errors++; $display("FAIL single_early_done c%0d got 1 exp 0", c); end
      @(negedge clk);
    end
    checks++;
    if ({bus.done, bus.result_valid} !== 2'b11) begin
      errors++; $display("FAIL single_done got %b exp 11", {bus.done, bus.result_valid});
    end
    checks++;
    if (bus.result !== 18'h001E0) begin errors++; $display("FAIL single_result got %h exp 001e0", bus.result); end
    @(negedge clk);
    checks++;
    if ({bus.done, bus.result_valid, bus.busy} !== 3'b000) begin
      errors++; $display("FAIL single_after got %b exp 000", {bus.done, bus.result_valid, bus.busy});
    end
  endtask
  task automatic test_multi_tap;
    int loads = 0, muls = 0, accs = 0, stores = 0, rvs = 0, done_at = 0;
    bus.data_in   = D1;
    bus.filter_in = F1;
    bus.in_valid  = 1'b1;
    start_pass(4'd3);
    for (int c = 1; c <= 16; c++) begin
      if (bus.pe_control[1:0] == CTRL_LOAD) loads++;
      if (bus.pe_control[1:0] == CTRL_EXEC && bus.pe_control2[2:0] == OP_MUL) muls++;
      if (bus.pe_control[1:0] == CTRL_EXEC && bus.pe_control2[2:0] == OP_ADD) accs++;
      if (bus.pe_control[1:0] == CTRL_STORE) stores++;
      if (bus.result_valid) rvs++;
      if (bus.done && done_at == 0) done_at = c;
      @(negedge clk);
    end
    checks++;
    if (loads != 3 || muls != 3 || accs != 3) begin
      errors++; $display("FAIL multi_phases got %0d/%0d/%0d exp 3/3/3", loads, muls, accs);
    end
    checks++;
    if (stores != 1) begin errors++; $display("FAIL multi_store got %0d exp 1", stores); end
    checks++;
    if (done_at != 12) begin errors++; $display("FAIL multi_done_at got %0d exp 12", done_at); end
    checks++;
    if (rvs != 1) begin errors++; $display("FAIL multi_rv_pulses got %0d exp 1", rvs); end
    checks++;
    if (bus.result !== 18'h005A0) begin errors++; $display("FAIL multi_result got %h exp 005a0", bus.result); end
  endtask
  task automatic test_stall;
    int done_at = 0;
    bus.data_in   = D1;
    bus.filter_in = F1;
    bus.in_valid  = 1'b1;
    start_pass(4'd2);
    for (int c = 1; c <= 20; c++) begin
      if (c >= 4 && c <= 6) begin
        checks++;
        if (bus.in_ready !== 1'b1 || bus.pe_data !== D1) begin
          errors++; $display("FAIL stall_hold c%0d got %b/%h exp 1/%h", c, bus.in_ready, bus.pe_data, D1);
        end
      end
      bus.in_valid = !(c >= 4 && c <= 6);
      bus.data_in  = (c >= 4 && c <= 6) ? 32'hDEADBEEF : D1;
      if (bus.done && done_at == 0) done_at = c;
      @(negedge clk);
    end
    checks++;
    if (done_at != 12) begin errors++; $display("FAIL stall_done_at got %0d exp 12", done_at); end
    checks++;
    if (bus.result !== 18'h003C0) begin errors++; $display("FAIL stall_result got %h exp 003c0", bus.result); end
    bus.in_valid = 1'b1;
  endtask
  task automatic test_zero_taps;
    int done_at = 0;
    force_ff = 1'b1;
    start_pass(4'd0);
    for (int c = 1; c <= 12; c++) begin
      if (bus.done && done_at == 0) done_at = c;
      @(negedge clk);
    end
    checks++;
    if (done_at != 6) begin errors++; $display("FAIL zero_done_at got %0d exp 6", done_at); end
    checks++;
    if (bus.result !== 18'h3FFFC) begin errors++; $display("FAIL zero_result got %h exp 3fffc", bus.result); end
    force_ff = 1'b0;
  endtask
  task automatic test_start_busy;
    int done_at = 0, dones = 0;
    bus.data_in   = D1;
    bus.filter_in = F1;
    start_pass(4'd1);
    for (int c = 1; c <= 12; c++) begin
      bus.start = c == 2;
      if (c == 2) bus.num_taps = 4'd5;
      if (c == 3) begin
        checks++;
        if (bus.busy !== 1'b1) begin errors++; $display("FAIL busy_mid got %b exp 1", bus.busy); end
      end
      if (bus.done) dones++;
      if (bus.done && done_at == 0) done_at = c;
      @(negedge clk);
    end
    checks++;
    if (dones != 1 || done_at != 6) begin
      errors++; $display("FAIL busy_start_ignored got %0d@%0d exp 1@6", dones, done_at);
    end
    checks++;
    if (bus.result !== 18'h001E0) begin errors++; $display("FAIL busy_result got %h exp 001e0", bus.result); end
  endtask
  task automatic test_rst_mid;
    int dones = 0;
    start_pass(4'd2);
    repeat (2) @(negedge clk);
    checks++;
    if (bus.pe_control !== 8'h55 || bus.pe_control2 !== 12'h000) begin
      errors++; $display("FAIL rst_in_acc got %h/%h exp 55/000", bus.pe_control, bus.pe_control2);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.pe_control !== 8'hFF || bus.busy !== 1'b0) begin
      errors++; $display("FAIL rst_mid_ctrl got %h/%b exp ff/0", bus.pe_control, bus.busy);
    end
    checks++;
    if ({bus.done, bus.result_valid} !== 2'b00 || bus.pe_data !== '0 || bus.result !== '0) begin
      errors++; $display("FAIL rst_mid_vals got %b/%h/%h exp 00/0/0", {bus.done, bus.result_valid}, bus.pe_data, bus.result);
    end
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (bus.done || bus.busy) dones++;
      @(negedge clk);
    end
    checks++;
    if (dones != 0) begin errors++; $display("FAIL rst_mid_quiet got %0d exp 0", dones); end
  endtask
  task automatic test_back_to_back;
    int done_at = 0;
    logic seen = 1'b0;
    bus.data_in   = D1;
    bus.filter_in = F1;
    bus.in_valid  = 1'b1;
    start_pass(4'd1);
    for (int c = 1; c <= 12 && !seen; c++) begin
      if (bus.done) seen = 1'b1;
      else @(negedge clk);
    end
    checks++;
    if (!seen || bus.result !== 18'h001E0) begin
      errors++; $display("FAIL b2b_first got %b/%h exp 1/001e0", seen, bus.result);
    end
    bus.data_in   = D2;
    bus.filter_in = F2;
    bus.num_taps  = 4'd1;
    bus.start     = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
      errors++; $display("FAIL b2b_restart got %b/%b exp 1/0", bus.busy, bus.done);
    end
    for (int c = 1; c <= 12; c++) begin
      if (bus.done && done_at == 0) done_at = c;
      @(negedge clk);
    end
    checks++;
    if (done_at != 6) begin errors++; $display("FAIL b2b_done_at got %0d exp 6", done_at); end
    checks++;
    if (bus.result !== 18'h00046) begin errors++; $display("FAIL b2b_result got %h exp 00046", bus.result); end
  endtask
  initial begin
    bus.start     = 1'b0;
    bus.num_taps  = '0;
    bus.in_valid  = 1'b0;
    bus.data_in   = '0;
    bus.filter_in = '0;
    test_reset;
    test_single_tap;
    test_multi_tap;
    test_stall;
    test_zero_taps;
    test_start_busy;
    test_rst_mid;
    test_back_to_back;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end
endmodule
